// File: rtl/router_pkg.sv
// router_pkg: shared constants and types for the 16x16 serial router arbiter.
//   NPORT       number of input and output ports
//   AW          destination address width, log2(NPORT)
//   in_state_e  per-input header/transfer FSM state
//   port_idx_t  port index type
package router_pkg;

    localparam int NPORT = 16;
    localparam int AW    = 4;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        REQ,
        XFER
    } in_state_e;

    typedef logic [AW-1:0] port_idx_t;

endpackage

// File: rtl/router_rr_arb.sv
// router_rr_arb: round-robin arbiter for a single output port.
// Holds the lock, the owning source index and the last-granted pointer.
//   clk, rst_n  clock, asynchronous active-low reset
//   req         per-input request for this output (input is in REQ)
//   rel         per-input release strobe; only the current owner's bit matters
//   lock        output is owned
//   src         index of the owning input (meaningful while lock is high)
//   win         one-hot, combinational: input granted on the coming edge
module router_rr_arb
    import router_pkg::*;
#(
    parameter int NPORT = router_pkg::NPORT,
    parameter int AW    = router_pkg::AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NPORT-1:0] req,
    input  logic [NPORT-1:0] rel,
    output logic             lock,
    output logic [AW-1:0]    src,
    output logic [NPORT-1:0] win
);

    logic [AW-1:0] last_grant;
    logic [AW-1:0] pick;
    logic [AW-1:0] idx;
    logic          found;
    logic          drop;

    // Search starts one past the last winner and wraps, so the last winner
    // is considered last.
    // NOTE: every variable assigned in always_comb gets a default first,
    // otherwise paths that skip the assignment infer latches.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int off = 1; off <= NPORT; off++) begin
            idx = AW'((int'(last_grant) + off) % NPORT);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        win = '0;
        if (!lock && found) begin
            win[pick] = 1'b1;
        end
    end

    assign drop = lock && rel[src];

    // A release takes priority, so a request arriving on the release edge
    // is only served on the following edge.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock       <= 1'b0;
            src        <= '0;
            last_grant <= AW'(NPORT - 1);
        end else if (drop) begin
            lock <= 1'b0;
        end else if (!lock && found) begin
            lock       <= 1'b1;
            src        <= pick;
            last_grant <= pick;
        end
    end

endmodule

// File: rtl/router_arbiter.sv
// router_arbiter: output-port arbiter for the 16x16 serial router.
// Each input snoops its serial header (4 address bits, LSB first) and then
// requests the addressed output; each output grants one input at a time with
// round-robin priority and holds the grant until the frame's last data bit.
//   clk, rst_n  clock, asynchronous active-low reset
//   frame_n     per-input frame strobe, active-low
//   valid_n     per-input data-valid strobe, active-low
//   din         per-input serial bit
//   grant       per input: input currently owns its destination output
//   out_lock    per output: output is owned
//   out_src     per output: owning input index, output k at [k*AW +: AW]
//   busy_n      per output: ~out_lock
//   err         per input: one-cycle pulse on forced release
// Optional feature: define ROUTER_ARB_TIMEOUT_EN to force-release an input
// that stays granted for TIMEOUT consecutive cycles without valid data.
module router_arbiter
    import router_pkg::*;
#(
    parameter int NPORT   = router_pkg::NPORT,
    parameter int AW      = router_pkg::AW,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NPORT-1:0]    frame_n,
    input  logic [NPORT-1:0]    valid_n,
    input  logic [NPORT-1:0]    din,
    output logic [NPORT-1:0]    grant,
    output logic [NPORT-1:0]    out_lock,
    output logic [NPORT*AW-1:0] out_src,
    output logic [NPORT-1:0]    busy_n,
    output logic [NPORT-1:0]    err
);

    if (NPORT != 2**AW || TIMEOUT < 1) begin : g_bad_cfg
        $error("router_arbiter: NPORT must equal 2**AW and TIMEOUT must be positive");
    end

    logic [NPORT-1:0]       req_valid;    // input is in REQ and frame still open
    logic [NPORT-1:0]       rel;          // input releases its output this edge
    logic [NPORT-1:0]       timeout_hit;  // forced release this edge
    logic [NPORT-1:0]       won;          // input granted on this edge
    logic [NPORT*AW-1:0]    addr_flat;
    logic [NPORT*NPORT-1:0] win_flat;     // output k's one-hot win at [k*NPORT +: NPORT]

    // ---------------------------------------------------------------------
    // Per-input header/transfer FSMs
    // ---------------------------------------------------------------------
    for (genvar i = 0; i < NPORT; i++) begin : g_in
        in_state_e     state;
        logic [AW-1:0] addr;
        logic [AW-1:0] bit_cnt;
        logic          armed;    // frame_n seen high since reset / forced release
        logic          grant_q;

        assign req_valid[i]          = (state == REQ) && !frame_n[i];
        assign rel[i]                = (state == XFER) &&
                                       ((frame_n[i] && !valid_n[i]) || timeout_hit[i]);
        assign addr_flat[i*AW +: AW] = addr;
        assign grant[i]              = grant_q;

`ifdef ROUTER_ARB_TIMEOUT_EN
        localparam int CW = $clog2(TIMEOUT + 1);
        logic [CW-1:0] idle_cnt;
        logic          err_q;

        // Fires on the TIMEOUT-th consecutive granted cycle with valid_n high.
        assign timeout_hit[i] = (state == XFER) && valid_n[i] &&
                                (idle_cnt == CW'(TIMEOUT - 1));
        assign err[i]         = err_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                idle_cnt <= '0;
                err_q    <= 1'b0;
            end else begin
                err_q <= timeout_hit[i];
                if (state != XFER || !valid_n[i] || timeout_hit[i]) begin
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
`else
        assign timeout_hit[i] = 1'b0;
        assign err[i]         = 1'b0;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= IDLE;
                addr    <= '0;
                bit_cnt <= '0;
                armed   <= 1'b0;
                grant_q <= 1'b0;
            end else begin
                // A frame already open at reset release (or at a forced
                // release) is ignored until frame_n is seen high.
                armed <= frame_n[i] | (armed & ~timeout_hit[i]);

                case (state)
                    IDLE: begin
                        if (armed && !frame_n[i]) begin
                            state   <= ADDR;
                            addr    <= {din[i], addr[AW-1:1]};
                            bit_cnt <= AW'(1);
                        end
                    end
                    ADDR: begin
                        if (frame_n[i]) begin
                            state <= IDLE;
                        end else begin
                            addr <= {din[i], addr[AW-1:1]};
                            if (bit_cnt == AW'(AW - 1)) begin
                                state <= REQ;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    REQ: begin
                        if (frame_n[i]) begin
                            state <= IDLE;
                        end else if (won[i]) begin
                            state   <= XFER;
                            grant_q <= 1'b1;
                        end
                    end
                    XFER: begin
                        if (rel[i]) begin
                            state   <= IDLE;
                            grant_q <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // Per-output arbiters
    // ---------------------------------------------------------------------
    for (genvar k = 0; k < NPORT; k++) begin : g_out
        logic [NPORT-1:0] req_k;
        logic [NPORT-1:0] win_k;
        logic [AW-1:0]    src_k;

        always_comb begin
            req_k = '0;
            for (int i = 0; i < NPORT; i++) begin
                req_k[i] = req_valid[i] && (addr_flat[i*AW +: AW] == AW'(k));
            end
        end

        router_rr_arb #(
            .NPORT (NPORT),
            .AW    (AW)
        ) u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (req_k),
            .rel   (rel),
            .lock  (out_lock[k]),
            .src   (src_k),
            .win   (win_k)
        );

        assign out_src[k*AW +: AW]        = src_k;
        assign win_flat[k*NPORT +: NPORT] = win_k;
    end

    // An input requests exactly one output, so at most one arbiter wins it.
    always_comb begin
        won = '0;
        for (int k = 0; k < NPORT; k++) begin
            won = won | win_flat[k*NPORT +: NPORT];
        end
    end

    assign busy_n = ~out_lock;

endmodule
